// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand fetch/issue stage with scalar register file, feeding a combinational ALU
module alu_operand_stage #(
  parameter int DATA_IN_WIDTH  = 32,
  parameter int OP_CODE_WIDTH  = 4,
  parameter int DATA_OUT_WIDTH = 64,
  parameter int NUM_REGS       = 16,
  localparam int ADDR_WIDTH    = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [OP_CODE_WIDTH-1:0]  instr_op,
  input  logic [ADDR_WIDTH-1:0]     instr_rd,
  input  logic [ADDR_WIDTH-1:0]     instr_rs1,
  input  logic [ADDR_WIDTH-1:0]     instr_rs2,
  input  logic                      host_wr_en,
  input  logic [ADDR_WIDTH-1:0]     host_wr_addr,
  input  logic [DATA_IN_WIDTH-1:0]  host_wr_data,
  output logic [DATA_IN_WIDTH-1:0]  scalar_a,
  output logic [DATA_IN_WIDTH-1:0]  scalar_b,
  output logic [OP_CODE_WIDTH-1:0]  op_code,
  input  logic [DATA_OUT_WIDTH-1:0] alu_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_OUT_WIDTH-1:0] res_data,
  output logic [ADDR_WIDTH-1:0]     res_rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                   state;
  logic [DATA_IN_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_IN_WIDTH-1:0] rd_a;
  logic [DATA_IN_WIDTH-1:0] rd_b;

  // Register 0 is hardwired to zero regardless of array contents.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (instr_rs1 != '0) rd_a = regs[instr_rs1];
    if (instr_rs2 != '0) rd_b = regs[instr_rs2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      res_valid   <= 1'b0;
      scalar_a    <= '0;
      scalar_b    <= '0;
      op_code     <= '0;
      res_data    <= '0;
      res_rd      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // Host write first; a writeback to the same address later in this block overrides it.
      if (host_wr_en && host_wr_addr != '0)
        regs[host_wr_addr] <= host_wr_data;

      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            scalar_a    <= rd_a;
            scalar_b    <= rd_b;
            op_code     <= instr_op;
            res_rd      <= instr_rd;
            instr_ready <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data  <= alu_out;
          if (res_rd != '0)
            regs[res_rd] <= alu_out[DATA_IN_WIDTH-1:0];
          res_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          res_valid   <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [3:0]  instr_rd;
  logic [3:0]  instr_rs1;
  logic [3:0]  instr_rs2;
  logic        host_wr_en;
  logic [3:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic [31:0] scalar_a;
  logic [31:0] scalar_b;
  logic [3:0]  op_code;
  logic [63:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [3:0]  res_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .scalar_a(scalar_a), .scalar_b(scalar_b), .op_code(op_code), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd)
  );

  // External ALU: 0 add, 1 sub, 2 pass A, 3 multiply (full 64-bit product).
  always_comb begin
    alu_out = '0;
    case (op_code)
      4'd0: alu_out = 64'(scalar_a) + 64'(scalar_b);
      4'd1: alu_out = 64'(scalar_a) - 64'(scalar_b);
      4'd2: alu_out = 64'(scalar_a);
      4'd3: alu_out = 64'(scalar_a) * 64'(scalar_b);
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [3:0] addr, input logic [31:0] data);
    host_wr_en = 1'b1; host_wr_addr = addr; host_wr_data = data;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
  endtask

  // Full transaction with res_ready high; optional host write during EXEC.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [31:0] exp_a, input logic [31:0] exp_b,
                       input logic [63:0] exp, input string tag,
                       input logic hw = 1'b0, input logic [3:0] haddr = 4'd0,
                       input logic [31:0] hdata = 32'd0);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " ready"}, 64'(instr_ready), 64'd1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (hw) begin host_wr_en = 1'b1; host_wr_addr = haddr; host_wr_data = hdata; end
    @(negedge clk);
    check({tag, " exec res_valid"}, 64'(res_valid), 64'd0);
    check({tag, " exec instr_ready"}, 64'(instr_ready), 64'd0);
    check({tag, " scalar_a"}, 64'(scalar_a), 64'(exp_a));
    check({tag, " scalar_b"}, 64'(scalar_b), 64'(exp_b));
    check({tag, " op_code"}, 64'(op_code), 64'(op));
    @(posedge clk); #1;
    host_wr_en = 1'b0;
    @(negedge clk);
    check({tag, " res_valid"}, 64'(res_valid), 64'd1);
    check({tag, " res_data"}, res_data, exp);
    check({tag, " res_rd"}, 64'(res_rd), 64'(rd));
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " res_valid drop"}, 64'(res_valid), 64'd0);
    check({tag, " idle ready"}, 64'(instr_ready), 64'd1);
  endtask

  task automatic read_reg(input logic [3:0] r, input logic [31:0] exp, input string tag);
    issue(4'd2, 4'd0, r, 4'd0, exp, 32'd0, 64'(exp), tag);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst instr_ready", 64'(instr_ready), 64'd1);
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst scalar_a", 64'(scalar_a), 64'd0);
    check("rst scalar_b", 64'(scalar_b), 64'd0);
    check("rst op_code", 64'(op_code), 64'd0);
    check("rst res_data", res_data, 64'd0);
    check("rst res_rd", 64'(res_rd), 64'd0);

    host_write(4'd1, 32'd7);
    host_write(4'd2, 32'd5);
    issue(4'd0, 4'd3, 4'd1, 4'd2, 32'd7, 32'd5, 64'd12, "add r3");
    issue(4'd1, 4'd4, 4'd3, 4'd1, 32'd12, 32'd7, 64'd5, "dep sub r4");
    issue(4'd3, 4'd5, 4'd1, 4'd0, 32'd7, 32'd0, 64'd0, "mul by r0");
    read_reg(4'd3, 32'd12, "read r3");
    read_reg(4'd4, 32'd5, "read r4");

    // Backpressure in RESP
    res_ready = 1'b0;
    instr_valid = 1'b1; instr_op = 4'd0; instr_rd = 4'd7; instr_rs1 = 4'd1; instr_rs2 = 4'd2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp res_valid", 64'(res_valid), 64'd1);
      check("bp res_data", res_data, 64'd12);
      check("bp res_rd", 64'(res_rd), 64'd7);
      check("bp instr_ready", 64'(instr_ready), 64'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp release res_valid", 64'(res_valid), 64'd0);
    check("bp release ready", 64'(instr_ready), 64'd1);

    // Destination r0
    issue(4'd0, 4'd0, 4'd1, 4'd2, 32'd7, 32'd5, 64'd12, "rd0 add");
    read_reg(4'd0, 32'd0, "read r0 after wb");
    host_write(4'd0, 32'd9);
    read_reg(4'd0, 32'd0, "read r0 after host");

    // Same-address collision: writeback wins
    issue(4'd0, 4'd6, 4'd1, 4'd2, 32'd7, 32'd5, 64'd12, "coll r6", 1'b1, 4'd6, 32'd99);
    read_reg(4'd6, 32'd12, "read r6");
    // Host write to rs1 after accept: both commit, latched operand unchanged
    issue(4'd0, 4'd9, 4'd1, 4'd2, 32'd7, 32'd5, 64'd12, "host rs1", 1'b1, 4'd1, 32'd100);
    read_reg(4'd9, 32'd12, "read r9");
    read_reg(4'd1, 32'd100, "read r1");

    // Wide result: full product reported, low bits written back
    host_write(4'd13, 32'hFFFF_FFFF);
    issue(4'd3, 4'd14, 4'd13, 4'd2, 32'hFFFF_FFFF, 32'd5, 64'h4_FFFF_FFFB, "wide mul");
    read_reg(4'd14, 32'hFFFF_FFFB, "read r14");

    // Reset during EXEC
    instr_valid = 1'b1; instr_op = 4'd0; instr_rd = 4'd10; instr_rs1 = 4'd1; instr_rs2 = 4'd2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst res_valid", 64'(res_valid), 64'd0);
    check("midrst instr_ready", 64'(instr_ready), 64'd1);
    check("midrst res_data", res_data, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst res_valid later", 64'(res_valid), 64'd0);
    read_reg(4'd1, 32'd0, "midrst r1");
    read_reg(4'd3, 32'd0, "midrst r3");
    read_reg(4'd10, 32'd0, "midrst r10");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
